// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product datapath: FSM state encoding,
// product width and default accumulator/count widths.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PROD_W    = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_LEN_W = 8;

endpackage

// File: rtl/dot_acc_dp.sv
// Accumulator datapath: wide sum register plus a sticky carry-out flag.
// A clear strobe starts a fresh accumulation and an enable strobe adds one product.
module dot_acc_dp
  import dot_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One extra bit captures the carry out of the top accumulator bit.
  assign sum = {1'b0, acc_q} + (ACC_W + 1)'(prod_i);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/dot_acc16.sv
// Dot-product accumulator: sums a programmed number of 32-bit products
// received over a valid/ready port and presents the total on a result port.
module dot_acc16
  import dot_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             startGo;
  logic             beat;
  logic             lastBeat;

  assign startGo  = (state_q == IDLE) && start;
  assign beat     = (state_q == ACCUM) && in_valid;
  assign lastBeat = beat && (cnt_q == len_q - LEN_W'(1));

  // Handshake outputs decode from the state register alone.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (lastBeat) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (startGo) begin
      len_d = len;
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  dot_acc_dp #(
    .ACC_W(ACC_W)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(startGo),
    .en_i   (beat),
    .prod_i (in_prod),
    .acc_o  (out_acc),
    .ovf_o  (out_ovf)
  );

endmodule

// File: tb/tb_dot_acc16.sv
// Self-checking bench for dot_acc16: a default-width and a 33-bit instance
// share stimulus and are compared against an arithmetic model of the run.
module tb_dot_acc16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        inValid;
  logic [31:0] inProd;
  logic        outReady;

  logic        inReadyA, outValidA, ovfA, busyA;
  logic [39:0] accA;
  logic        inReadyB, outValidB, ovfB, busyB;
  logic [32:0] accB;

  int nChecks = 0;
  int nFail   = 0;

  dot_acc16 dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(inValid), .in_ready(inReadyA), .in_prod(inProd),
    .out_valid(outValidA), .out_ready(outReady), .out_acc(accA),
    .out_ovf(ovfA), .busy(busyA)
  );

  dot_acc16 #(.ACC_W(33), .LEN_W(8)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(inValid), .in_ready(inReadyB), .in_prod(inProd),
    .out_valid(outValidB), .out_ready(outReady), .out_acc(accB),
    .out_ovf(ovfB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The model treats the run as a plain integer sum; the result is that
  // sum reduced mod 2^W, and the overflow flag means the sum reached 2^W.
  task automatic checkResult(input string tag, input logic [63:0] total);
    checkOutput({tag, ".validA"}, 64'(outValidA), 64'd1);
    checkOutput({tag, ".validB"}, 64'(outValidB), 64'd1);
    checkOutput({tag, ".accA"}, 64'(accA), total % (64'd1 << 40));
    checkOutput({tag, ".ovfA"}, 64'(ovfA), 64'(total >= (64'd1 << 40)));
    checkOutput({tag, ".accB"}, 64'(accB), total % (64'd1 << 33));
    checkOutput({tag, ".ovfB"}, 64'(ovfB), 64'(total >= (64'd1 << 33)));
  endtask

  // stallMode: 0 always valid, 1 alternate valid, 2 random valid.
  // valMode: 0 random products, 1 constant val, 2 ramp val*(i+1).
  task automatic applyStimulus(input int n, input int stallMode, input int outStall,
                               input bit pokeStart, input int valMode,
                               input logic [31:0] val, input string tag);
    logic [31:0] p[$];
    logic [63:0] total;
    logic [31:0] v;
    int idx;
    int cyc;
    total = '0;
    for (int i = 0; i < n; i++) begin
      v = (valMode == 0) ? $urandom : (valMode == 1) ? val : val * (i + 1);
      p.push_back(v);
      total += 64'(v);
    end
    start = 1'b1;
    len   = n[7:0];
    tick();
    start = 1'b0;
    checkOutput({tag, ".busy"}, 64'(busyA), 64'd1);
    checkOutput({tag, ".readyAfterStart"}, 64'(inReadyA), 64'(n != 0));
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4 * n + 16) begin
      inValid = (stallMode == 0) ? 1'b1 : (stallMode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      inProd  = p[idx];
      start   = pokeStart && (cyc % 3 == 1);
      len     = 8'hFF;
      checkOutput({tag, ".inReady"}, 64'(inReadyB), 64'd1);
      tick();
      if (inValid) idx++;
      cyc++;
      inValid = 1'b0;
      start   = 1'b0;
      inProd  = $urandom;
      checkOutput({tag, ".validTiming"}, 64'(outValidA), 64'(idx == n));
    end
    checkOutput({tag, ".beatsTaken"}, 64'(idx), 64'(n));
    inValid = 1'b1;
    checkResult(tag, total);
    for (int s = 0; s < outStall; s++) begin
      start = pokeStart;
      tick();
      start = 1'b0;
      checkResult({tag, ".hold"}, total);
      checkOutput({tag, ".readyInDone"}, 64'(inReadyA), 64'd0);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    inValid  = 1'b0;
    checkOutput({tag, ".validDropA"}, 64'(outValidA), 64'd0);
    checkOutput({tag, ".validDropB"}, 64'(outValidB), 64'd0);
    checkOutput({tag, ".idleBusy"}, 64'(busyA | busyB), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    inValid  = 1'b0;
    inProd   = '0;
    outReady = 1'b0;
    #12;
    checkOutput("reset.inReady", 64'(inReadyA), 64'd0);
    checkOutput("reset.outValid", 64'(outValidA), 64'd0);
    checkOutput("reset.acc", 64'(accA), 64'd0);
    checkOutput("reset.ovf", 64'(ovfA), 64'd0);
    checkOutput("reset.busy", 64'(busyA), 64'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus(3, 0, 0, 1'b0, 2, 32'd10, "basic");
    applyStimulus(0, 0, 2, 1'b0, 1, 32'd0, "zeroLen");
    applyStimulus(4, 1, 5, 1'b0, 1, 32'hFFFE0001, "stall");
    applyStimulus(3, 0, 0, 1'b0, 1, 32'hFFFFFFFF, "ovf");
    applyStimulus(1, 0, 0, 1'b0, 1, 32'd5, "ovfCleared");

    // Abort a run after two beats with an asynchronous reset.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start   = 1'b0;
    inValid = 1'b1;
    inProd  = $urandom | 32'h1;
    tick();
    tick();
    inValid = 1'b0;
    checkOutput("midRun.accNonZero", 64'(accA != '0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRun.inReady", 64'(inReadyA), 64'd0);
    checkOutput("midRun.outValid", 64'(outValidA), 64'd0);
    checkOutput("midRun.acc", 64'(accA), 64'd0);
    checkOutput("midRun.accB", 64'(accB), 64'd0);
    checkOutput("midRun.busy", 64'(busyA), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 1'b0, 1, 32'd7, "postReset");

    applyStimulus(6, 1, 3, 1'b1, 0, 32'd0, "pokeStart");
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(1, 24), 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 32'd0, "random");
    end
    applyStimulus(255, 0, 0, 1'b0, 1, 32'hFFFFFFFF, "maxLen");

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/dot_acc16.md
# dot_acc16

Downstream consumer of the 16x16 Dadda multiplier's 32-bit product. It accumulates a programmed number of unsigned products into a wide accumulator, one per cycle under a valid/ready handshake. It then presents the dot-product result on a second valid/ready port. It sits between the multiplier output register and the result FIFO in the dot-product datapath.

## Interface
- `ACC_W`, default 40: accumulator and result width; must be ≥ 32.
- `LEN_W`, default 8: width of the product-count field.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  active-low reset, asserted asynchronously.
- `start`  in  1  single-cycle request to begin a new accumulation. Honoured only in IDLE.
- `len`  in  LEN_W  number of products to accumulate. Sampled when `start` is honoured.
- `in_valid`  in  1  `in_prod` is valid.
- `in_ready`  out  1  block accepts `in_prod` this cycle.
- `in_prod`  in  32  unsigned product from the multiplier.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  ACC_W  accumulated sum.
- `out_ovf`  out  1  sticky flag: a carry came out of bit ACC_W-1 during this accumulation.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, ACCUM, DONE.
- **IDLE**
  - `start`=1 latches `len` into `len_q`, clears `acc`, `cnt` and `ovf`.
  - Next state is ACCUM, or DONE directly when `len`=0 (result is 0).
- **ACCUM**
  - `in_ready`=1.
  - On each beat (`in_valid` & `in_ready`): `acc` ← `acc` + zero-extend(`in_prod`) and `cnt` ← `cnt`+1.
  - On the beat where `cnt` = `len_q`-1, next state is DONE.
  - Cycles with `in_valid`=0 leave all state unchanged.
- **DONE**
  - `out_valid`=1; `out_acc` and `out_ovf` hold stable until the handshake.
  - `out_valid` & `out_ready` returns the FSM to IDLE.
- **Arithmetic**
  - The sum is taken mod 2^ACC_W.
  - `ovf` is set by a carry out of the top bit and is never cleared within an accumulation.
  - At the defaults, 255 × (2^32−1) < 2^40, so `ovf` stays 0.
- **Ignored inputs**
  - `start` is ignored in ACCUM and DONE; it is not queued.
  - `in_valid` is ignored outside ACCUM, since `in_ready`=0 there.
- **Reset values** (all outputs 0, state IDLE; applies at any time, including mid-accumulation or mid-DONE): `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `busy`=0. Internal `acc`, `cnt`, `len_q` are also 0.

## Timing
- **Start to accept:** `start` honoured at edge k puts `in_ready` high from cycle k+1.
- **Throughput:** one product per cycle while `in_valid` stays high.
- **Result latency:** the last beat at edge m gives `out_valid`=1 in cycle m+1 with the final sum visible. No combinational path from `in_prod` to `out_acc`.
- **Back-to-back runs:** result handshake at edge n puts the FSM in IDLE in cycle n+1, where a new `start` is accepted. Minimum gap: 1 cycle.
- **Output outputs are registered/decoded:** `in_ready`, `out_valid`, `busy` are decoded from the state register only and never depend on same-cycle inputs.
- **`out_ready` held high in DONE:** result is taken in the first DONE cycle.

## Structure
- **Shared package `dot_pkg`:**
  - State enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
  - `PROD_W`=32.
  - Default `ACC_W`/`LEN_W` constants, reused by the result FIFO.
- **Sub-module `dot_acc_dp`:** accumulator register, adder with carry-out, and `ovf` flag, enabled by the beat strobe and cleared by the start strobe. The top level holds the FSM and counter.
- **Multiplier:** not instantiated here; it is instantiated by the parent.

## Test plan
- **Basic run:** `start`, `len`=3, products 10, 20, 30 on consecutive cycles → `out_valid` one cycle after the third beat, `out_acc`=60, `out_ovf`=0.
- **Zero length:** `len`=0 → DONE the cycle after `start`, `out_acc`=0, `in_ready` never asserted.
- **Stalls on both ports:** `len`=4 of 0xFFFE0001 with `in_valid` toggling 1,0,1,0… and `out_ready` held low 5 cycles in DONE → `out_acc`=0x3FFF80004, held stable until handshake, then IDLE.
- **Overflow:** `ACC_W`=33, `len`=3 of 0xFFFFFFFF → `out_acc`=0x0FFFFFFFD, `out_ovf`=1. The next run of `len`=1, value 5 → `out_ovf`=0, `out_acc`=5.
- **Reset mid-run:** assert `rst_n`=0 during ACCUM after 2 beats → all outputs 0 immediately. After release, a new `start` with `len`=1 and value 7 → `out_acc`=7.
- **Ignored start:** pulse `start` while in ACCUM and DONE → no effect on `cnt`/`acc`. Result matches a run without the extra pulses.
